// File: rtl/reg_dump_pkg.sv
// Shared definitions for the register-file dump reader and the register
// file instance it sits beside.
package reg_dump_pkg;

  localparam int unsigned DUMP_PW = 2;
  localparam int unsigned DUMP_DW = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } dump_state_t;

endpackage

// File: rtl/reg_file_dump_reader.sv
// Read-side sequencer for the register file. A start pulse walks a
// wrap-around address range, reads each entry through the file's
// combinational read port and presents {addr, data} on a valid/ready port.
module reg_file_dump_reader
  import reg_dump_pkg::*;
#(
  parameter int unsigned PW = DUMP_PW,
  parameter int unsigned DW = DUMP_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic [PW:0]   first_addr,
  input  logic [PW:0]   last_addr,
  output logic [PW:0]   rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW:0]   out_addr,
  output logic [DW-1:0] out_data,
  output logic          busy,
  output logic          done
);

  dump_state_t   state;
  dump_state_t   state_nxt;
  logic [PW-1:0] ptr;
  logic [PW-1:0] end_ptr;
  logic          hs;
  logic          last_word;

  // The top bit of the range inputs carries no meaning for an NREG-entry file.
  logic unused_range_hi;
  assign unused_range_hi = first_addr[PW] ^ last_addr[PW];

  assign hs        = out_valid & out_ready;
  assign last_word = (ptr == end_ptr);
  assign rd_addr   = {1'b0, ptr};
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  // Next-state selection; abort overrides start and any same-cycle handshake.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start && !abort) state_nxt = READ;
      READ: state_nxt = abort ? IDLE : SEND;
      SEND: begin
        if (abort)   state_nxt = IDLE;
        else if (hs) state_nxt = last_word ? DONE : READ;
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, range pointers and the registered output word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= '0;
      end_ptr   <= '0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: begin
          if (start && !abort) begin
            ptr     <= first_addr[PW-1:0];
            end_ptr <= last_addr[PW-1:0];
          end
        end
        READ: begin
          if (!abort) begin
            out_data  <= rd_data;
            out_addr  <= {1'b0, ptr};
            out_valid <= 1'b1;
          end
        end
        SEND: begin
          if (abort) begin
            out_valid <= 1'b0;
          end else if (hs) begin
            out_valid <= 1'b0;
            if (!last_word) ptr <= ptr + 1'b1;
          end
        end
        DONE: ;
        default: out_valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_file_dump_reader.sv
// Directed bench for reg_file_dump_reader: table-driven range dumps plus
// hand-written sequences for reset, backpressure, ignored start and abort.
module tb_reg_file_dump_reader;

  logic       clk = 1'b0;
  logic       reset, start, abort, out_ready;
  logic [2:0] first_addr, last_addr, rd_addr, out_addr;
  logic [7:0] rd_data, out_data;
  logic       out_valid, busy, done;

  logic [7:0] rf [4];
  assign rd_data = rf[rd_addr[1:0]];

  int total = 0;
  int bad   = 0;

  logic [2:0] got_addr [8];
  logic [7:0] got_data [8];
  int         got_n, busy_cyc, done_cnt;

  typedef struct {
    logic [2:0]      first;
    logic [2:0]      last;
    int              n;
    logic [3:0][2:0] addr;
    logic [3:0][7:0] data;
  } vec_t;

  vec_t vecs [5];

  reg_file_dump_reader #(.PW(2), .DW(8)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .first_addr(first_addr), .last_addr(last_addr),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_data(out_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_valid();
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    if (!seen) check("wait_valid_timeout", 0, 1);
  endtask

  // Runs one dump with the current out_ready and records accepted words.
  task automatic run_dump(input logic [2:0] f, input logic [2:0] l);
    bit finished;
    first_addr = f;
    last_addr  = l;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("latency_valid_lo", out_valid, 0);
    got_n = 0; busy_cyc = 0; done_cnt = 0; finished = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (!busy) begin
        finished = 1'b1;
        break;
      end
      if (c == 1) check("latency_valid_hi", out_valid, 1);
      if (!done) busy_cyc++;
      if (done) done_cnt++;
      if (out_valid && out_ready && got_n < 8) begin
        got_addr[got_n] = out_addr;
        got_data[got_n] = out_data;
        got_n++;
      end
      tick();
    end
    if (!finished) check("dump_timeout", 1, 0);
  endtask

  initial begin
    int delivered;
    bit aborted;

    rf[0] = 8'd11; rf[1] = 8'd22; rf[2] = 8'd33; rf[3] = 8'd44;

    vecs[0] = '{3'd0, 3'd3, 4, {3'd3, 3'd2, 3'd1, 3'd0}, {8'd44, 8'd33, 8'd22, 8'd11}};
    vecs[1] = '{3'd3, 3'd1, 3, {3'd0, 3'd1, 3'd0, 3'd3}, {8'd0,  8'd22, 8'd11, 8'd44}};
    vecs[2] = '{3'd2, 3'd2, 1, {3'd0, 3'd0, 3'd0, 3'd2}, {8'd0,  8'd0,  8'd0,  8'd33}};
    vecs[3] = '{3'd1, 3'd0, 4, {3'd0, 3'd3, 3'd2, 3'd1}, {8'd11, 8'd44, 8'd33, 8'd22}};
    vecs[4] = '{3'd6, 3'd7, 2, {3'd0, 3'd0, 3'd3, 3'd2}, {8'd0,  8'd0,  8'd44, 8'd33}};

    reset = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    first_addr = '0; last_addr = '0;
    #12;
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_out_addr", out_addr, 0);
    check("rst_out_data", out_data, 0);
    tick();
    reset = 1'b0;
    tick();

    // Reset asserted while a word is held in SEND clears outputs without a clock edge.
    out_ready = 1'b0;
    first_addr = 3'd1; last_addr = 3'd3;
    start = 1'b1; tick(); start = 1'b0;
    wait_valid();
    check("pre_rst_valid", out_valid, 1);
    reset = 1'b1;
    #2;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_done", done, 0);
    check("async_rst_rd_addr", rd_addr, 0);
    tick();
    reset = 1'b0;
    tick();
    check("post_rst_idle", busy, 0);

    // Table-driven dumps with out_ready held high.
    out_ready = 1'b1;
    for (int v = 0; v < 5; v++) begin
      run_dump(vecs[v].first, vecs[v].last);
      check($sformatf("v%0d_words", v), got_n, vecs[v].n);
      check($sformatf("v%0d_cycles", v), busy_cyc, 2 * vecs[v].n);
      check($sformatf("v%0d_done_cnt", v), done_cnt, 1);
      for (int w = 0; w < vecs[v].n && w < got_n; w++) begin
        check($sformatf("v%0d_w%0d_addr", v, w), got_addr[w], vecs[v].addr[w]);
        check($sformatf("v%0d_w%0d_data", v, w), got_data[w], vecs[v].data[w]);
      end
      tick();
    end

    // Backpressure: held word stays stable and the read pointer stays put.
    out_ready = 1'b0;
    first_addr = 3'd1; last_addr = 3'd2;
    start = 1'b1; tick(); start = 1'b0;
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid", out_valid, 1);
      check("bp_addr", out_addr, 1);
      check("bp_data", out_data, 22);
      check("bp_rd_addr", rd_addr, 1);
    end
    out_ready = 1'b1;
    tick();
    check("bp_after_hs_valid", out_valid, 0);
    check("bp_after_hs_rd_addr", rd_addr, 2);
    tick();
    check("bp_w1_valid", out_valid, 1);
    check("bp_w1_addr", out_addr, 2);
    check("bp_w1_data", out_data, 33);
    tick();
    check("bp_done", done, 1);
    tick();
    check("bp_idle", busy, 0);

    // Single word; start during SEND and during DONE is ignored.
    out_ready = 1'b0;
    first_addr = 3'd2; last_addr = 3'd2;
    start = 1'b1; tick(); start = 1'b0;
    wait_valid();
    first_addr = 3'd0; last_addr = 3'd3;
    start = 1'b1; tick(); start = 1'b0;
    check("ign_valid", out_valid, 1);
    check("ign_addr", out_addr, 2);
    check("ign_data", out_data, 33);
    out_ready = 1'b1;
    tick();
    check("ign_done", done, 1);
    check("ign_done_busy", busy, 1);
    start = 1'b1; tick(); start = 1'b0;
    check("ign_idle_busy", busy, 0);
    check("ign_idle_done", done, 0);
    tick();
    check("ign_no_restart", busy, 0);

    // Abort on the second word's handshake cycle.
    out_ready = 1'b1;
    first_addr = 3'd0; last_addr = 3'd3;
    start = 1'b1; tick(); start = 1'b0;
    delivered = 0; aborted = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (out_valid) begin
        if (delivered == 1) begin
          abort = 1'b1;
          tick();
          abort = 1'b0;
          aborted = 1'b1;
          break;
        end
        delivered++;
      end
      tick();
    end
    check("abort_reached", aborted, 1);
    check("abort_delivered", delivered, 1);
    check("abort_busy", busy, 0);
    check("abort_valid", out_valid, 0);
    check("abort_done", done, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("abort_no_done", done, 0);
    end

    // start and abort together in IDLE: abort wins.
    start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
    check("sa_busy", busy, 0);
    tick();
    check("sa_stay_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
